// File: rtl/ysyx_22040759_scoreboard_pkg.sv
// Shared scoreboard constants. These mirror the ysyx_22040759_define.v
// values so the scoreboard defaults track the rest of the core.
package ysyx_22040759_scoreboard_pkg;

    // Architectural register address width.
    localparam int unsigned SbRaw    = 5;
    // Architectural register count (2**SbRaw).
    localparam int unsigned SbNreg   = 32;
    // Maximum in-flight long-latency writes to a single register.
    localparam int unsigned SbMaxOut = 3;

    // Width needed to count 0..max_out inclusive.
    function automatic int unsigned sb_cnt_width(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/ysyx_22040759_sb_cnt.sv
// Per-register pending-write counter: increments on issue of a long-latency
// write, decrements on its retirement and flags a retire with nothing pending.
module ysyx_22040759_sb_cnt #(
    parameter int unsigned CW      = 2,
    parameter int unsigned MAX_OUT = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          underflow_o
);

    localparam logic [CW-1:0] MaxCnt = CW'(MAX_OUT);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count; a coincident inc and dec cancel and cannot underflow.
    always_comb begin
        cnt_d       = cnt_q;
        underflow_o = 1'b0;
        if (inc_i && !dec_i) begin
            // Issue is already blocked at MaxCnt; saturate as a backstop.
            if (cnt_q != MaxCnt) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) begin
                underflow_o = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ysyx_22040759_scoreboard.sv
// Register scoreboard for long-latency writes (load/mul/div). Tracks pending
// writes per register and stalls ID on RAW, WAW and per-register overflow.
// Define YSYX_22040759_HZD_PERF_EN to add the stall_cycles perf counter.
module ysyx_22040759_scoreboard
    import ysyx_22040759_scoreboard_pkg::*;
#(
    parameter int unsigned NREG    = SbNreg,
    parameter int unsigned RAW     = SbRaw,
    parameter int unsigned MAX_OUT = SbMaxOut
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           id_valid,
    input  logic           id_fire,
    input  logic [RAW-1:0] id_rs1,
    input  logic [RAW-1:0] id_rs2,
    input  logic [RAW-1:0] id_rd,
    input  logic           id_rs1_ren,
    input  logic           id_rs2_ren,
    input  logic           id_rd_wen,
    input  logic           id_long,
    input  logic           wb_valid,
    input  logic           wb_long,
    input  logic [RAW-1:0] wb_rd,
    output logic           pcwrite,
    output logic           IF_ID_write,
    output logic           en_control,
    output logic           err_underflow
`ifdef YSYX_22040759_HZD_PERF_EN
    ,
    output logic [31:0]    stall_cycles
`endif
);

    localparam int unsigned   CW     = sb_cnt_width(MAX_OUT);
    localparam logic [CW-1:0] MaxCnt = CW'(MAX_OUT);

    logic [CW-1:0]   cnt_all [NREG];
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;
    logic [NREG-1:0] uflow_vec;

    logic haz_raw, haz_waw, haz_full;
    logic rs1_busy, rs2_busy;
    logic stall_hz, stall;
    logic inc_en, dec_en;
    logic err_q, err_d;

    // Hazard detection from registered counts and live ID fields.
    always_comb begin
        rs1_busy = id_rs1_ren && (id_rs1 != '0) && (cnt_all[id_rs1] != '0);
        rs2_busy = id_rs2_ren && (id_rs2 != '0) && (cnt_all[id_rs2] != '0);
        haz_raw  = id_valid && (rs1_busy || rs2_busy);
        haz_waw  = id_valid && id_rd_wen && (id_rd != '0) && (cnt_all[id_rd] != '0) && !id_long;
        haz_full = id_valid && id_rd_wen && id_long && (id_rd != '0)
                   && (cnt_all[id_rd] == MaxCnt);
        stall_hz = haz_raw || haz_waw || haz_full;
        // Outputs are quiet during reset; counters are being cleared anyway.
        stall    = rst_n && stall_hz;
        // A fire while stalled is not a real issue.
        inc_en   = id_fire && id_rd_wen && id_long && (id_rd != '0) && !stall_hz;
        // Retirement takes effect next cycle: no same-cycle forwarding.
        dec_en   = wb_valid && wb_long && (wb_rd != '0);
    end

    assign pcwrite     = stall;
    assign IF_ID_write = stall;
    assign en_control  = stall;

    // Register 0 is hard-wired zero and never pends.
    assign cnt_all[0]   = '0;
    assign inc_vec[0]   = 1'b0;
    assign dec_vec[0]   = 1'b0;
    assign uflow_vec[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_cnt
        assign inc_vec[i] = inc_en && (id_rd == RAW'(i));
        assign dec_vec[i] = dec_en && (wb_rd == RAW'(i));

        ysyx_22040759_sb_cnt #(
            .CW      (CW),
            .MAX_OUT (MAX_OUT)
        ) u_cnt (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .inc_i       (inc_vec[i]),
            .dec_i       (dec_vec[i]),
            .cnt_o       (cnt_all[i]),
            .underflow_o (uflow_vec[i])
        );
    end

    // Sticky underflow: any retire with nothing pending.
    always_comb begin
        err_d = err_q || (|uflow_vec);
    end

    // Underflow flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_underflow = err_q;

`ifdef YSYX_22040759_HZD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Perf counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_22040759_scoreboard.sv
// Directed self-checking bench for ysyx_22040759_scoreboard.
module tb_ysyx_22040759_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       id_valid, id_fire;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_ren, id_rs2_ren, id_rd_wen, id_long;
    logic       wb_valid, wb_long;
    logic [4:0] wb_rd;
    logic       pcwrite, IF_ID_write, en_control, err_underflow;
`ifdef YSYX_22040759_HZD_PERF_EN
    logic [31:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_22040759_scoreboard dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_fire       (id_fire),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_rs1_ren    (id_rs1_ren),
        .id_rs2_ren    (id_rs2_ren),
        .id_rd_wen     (id_rd_wen),
        .id_long       (id_long),
        .wb_valid      (wb_valid),
        .wb_long       (wb_long),
        .wb_rd         (wb_rd),
        .pcwrite       (pcwrite),
        .IF_ID_write   (IF_ID_write),
        .en_control    (en_control),
        .err_underflow (err_underflow)
`ifdef YSYX_22040759_HZD_PERF_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic f, input logic [4:0] rs1, input logic r1,
                          input logic [4:0] rs2, input logic r2, input logic [4:0] rd,
                          input logic w, input logic lng);
        id_valid   = v;
        id_fire    = f;
        id_rs1     = rs1;
        id_rs1_ren = r1;
        id_rs2     = rs2;
        id_rs2_ren = r2;
        id_rd      = rd;
        id_rd_wen  = w;
        id_long    = lng;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd);
        wb_valid = v;
        wb_long  = v;
        wb_rd    = rd;
    endtask

    // All three stall outputs must agree with the expected stall.
    task automatic check_stall(input string tag, input logic exp);
        #1;
        check_eq(tag, {29'd0, pcwrite, IF_ID_write, en_control}, exp ? 32'd7 : 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_id(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        set_wb(1'b0, 5'd0);
        tick();
        tick();
        check_stall("reset_stall", 1'b0);
        check_eq("reset_err", {31'd0, err_underflow}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("post_reset_cnt5", 32'(dut.cnt_all[5]), 32'd0);
`ifdef YSYX_22040759_HZD_PERF_EN
        check_eq("perf_reset", stall_cycles, 32'd0);
`endif

        // Load x5 then a consumer of x5: stalls until the retire edge passes.
        set_id(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        check_stall("t1_load_fire", 1'b0);
        tick();
        check_eq("t1_cnt5_one", 32'(dut.cnt_all[5]), 32'd1);
        set_id(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check_stall("t1_raw_stall", 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            check_stall("t1_raw_hold", 1'b1);
        end
        set_wb(1'b1, 5'd5);
        check_stall("t1_retire_cycle", 1'b1);
        tick();
        set_wb(1'b0, 5'd0);
        check_stall("t1_after_retire", 1'b0);
        check_eq("t1_cnt5_zero", 32'(dut.cnt_all[5]), 32'd0);
`ifdef YSYX_22040759_HZD_PERF_EN
        check_eq("perf_count", stall_cycles, 32'd3);
`endif

        // x0 reads never stall, x0 loads never count.
        set_id(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
        check_stall("t2_rs_x0", 1'b0);
        tick();
        for (int i = 0; i < 32; i++) begin
            check_eq($sformatf("t2_cnt%0d", i), 32'(dut.cnt_all[i]), (i == 5) ? 32'd1 : 32'd0);
        end
        set_id(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        set_wb(1'b1, 5'd5);
        tick();
        set_wb(1'b0, 5'd0);

        // Fill x7 to MAX_OUT, then the fourth long op waits for one retire.
        set_id(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check_stall("t3_fire", 1'b0);
            tick();
        end
        check_eq("t3_cnt7_full", 32'(dut.cnt_all[7]), 32'd3);
        check_stall("t3_full_stall", 1'b1);
        tick();
        check_eq("t3_cnt7_held", 32'(dut.cnt_all[7]), 32'd3);
        set_wb(1'b1, 5'd7);
        check_stall("t3_retire_stall", 1'b1);
        tick();
        set_wb(1'b0, 5'd0);
        check_eq("t3_cnt7_two", 32'(dut.cnt_all[7]), 32'd2);
        check_stall("t3_refire_go", 1'b0);
        tick();
        check_eq("t3_cnt7_refill", 32'(dut.cnt_all[7]), 32'd3);
        set_id(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        set_wb(1'b1, 5'd7);
        for (int k = 0; k < 3; k++) tick();
        set_wb(1'b0, 5'd0);
        check_eq("t3_cnt7_drained", 32'(dut.cnt_all[7]), 32'd0);
        check_eq("t3_no_err", {31'd0, err_underflow}, 32'd0);

        // Coincident inc/dec on x9 cancels; retire of idle x4 is sticky error.
        set_id(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        tick();
        set_wb(1'b1, 5'd9);
        check_stall("t4_same_cycle", 1'b0);
        tick();
        check_eq("t4_cnt9_same", 32'(dut.cnt_all[9]), 32'd1);
        set_id(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        check_eq("t4_cnt9_zero", 32'(dut.cnt_all[9]), 32'd0);
        check_eq("t4_err_clear", {31'd0, err_underflow}, 32'd0);
        set_wb(1'b1, 5'd4);
        tick();
        set_wb(1'b0, 5'd0);
        check_eq("t4_err_set", {31'd0, err_underflow}, 32'd1);
        check_eq("t4_cnt4_zero", 32'(dut.cnt_all[4]), 32'd0);
        tick();
        tick();
        check_eq("t4_err_sticky", {31'd0, err_underflow}, 32'd1);

        // WAW: ALU write to x3 with two loads pending holds until x3 drains.
        set_id(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
        tick();
        tick();
        check_eq("t5_cnt3_two", 32'(dut.cnt_all[3]), 32'd2);
        set_id(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        check_stall("t5_waw", 1'b1);
        set_wb(1'b1, 5'd3);
        tick();
        check_eq("t5_cnt3_one", 32'(dut.cnt_all[3]), 32'd1);
        check_stall("t5_waw_hold", 1'b1);
        tick();
        set_wb(1'b0, 5'd0);
        check_eq("t5_cnt3_zero", 32'(dut.cnt_all[3]), 32'd0);
        check_stall("t5_waw_clear", 1'b0);

        // Reset in the middle of a RAW stall.
        set_id(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check_stall("t6_pre_reset", 1'b1);
        rst_n = 1'b0;
        check_stall("t6_in_reset", 1'b0);
        set_id(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        check_eq("t6_cnt5", 32'(dut.cnt_all[5]), 32'd0);
        check_eq("t6_cnt6", 32'(dut.cnt_all[6]), 32'd0);
        check_eq("t6_err_cleared", {31'd0, err_underflow}, 32'd0);
`ifdef YSYX_22040759_HZD_PERF_EN
        check_eq("perf_cleared", stall_cycles, 32'd0);
`endif
        rst_n = 1'b1;
        set_id(1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check_stall("t6_after_reset", 1'b0);
        set_wb(1'b1, 5'd5);
        tick();
        set_wb(1'b0, 5'd0);
        check_eq("t6_stale_retire", {31'd0, err_underflow}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
